// File: rtl/person_pkg.sv
// person_pkg: shared state encoding, body-part geometry and box helpers for the player sprite.
package person_pkg;

    typedef enum logic [1:0] {STAND, WALK, JUMP} state_t;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam int PERSON_H = 66;

    localparam int HEAD_DX  = 4;
    localparam int HEAD_W   = 12;
    localparam int HEAD_H   = 12;
    localparam int TORSO_DY = 12;
    localparam int TORSO_W  = 20;
    localparam int TORSO_H  = 30;
    localparam int ARM_DX   = 6;
    localparam int ARM_DY   = 16;
    localparam int ARM_W    = 32;
    localparam int ARM_H    = 6;
    localparam int ARM_LIFT = 2;
    localparam int LEG_DX   = 2;
    localparam int LEG_DY   = 42;
    localparam int LEG_W    = 16;
    localparam int LEG_H    = 24;
    localparam int LEG_SWING = 2;

    typedef struct packed {
        logic [9:0] h_min;
        logic [9:0] h_max;
        logic [9:0] v_min;
        logic [9:0] v_max;
    } box_t;

    typedef struct packed {
        box_t head;
        box_t torso;
        box_t legs;
        box_t arms;
    } parts_t;

    function automatic box_t mk_box(input int l, input int t, input int w, input int h);
        return '{10'(l), 10'(l + w - 1), 10'(t), 10'(t + h - 1)};
    endfunction

    // d shifts the legs sideways, a lifts the arms; both are zero when standing still
    function automatic parts_t geom(input int x, input int y, input int d, input int a);
        return '{mk_box(x + HEAD_DX, y, HEAD_W, HEAD_H),
                 mk_box(x, y + TORSO_DY, TORSO_W, TORSO_H),
                 mk_box(x + LEG_DX + d, y + LEG_DY, LEG_W, LEG_H),
                 mk_box(x - ARM_DX, y + ARM_DY + a, ARM_W, ARM_H)};
    endfunction

endpackage

// File: rtl/person_motion_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse on the cycle after a registered vblank rising edge.
module frame_tick_gen (
    input  logic pclk,
    input  logic rst_n,
    input  logic vblnk_i,
    output logic tick_o
);
    logic vblnk_q, vblnk_prev_q, tick_q;

    // history resets high so a vblank already asserted at release is not seen as an edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q      <= 1'b1;
            vblnk_prev_q <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            vblnk_q      <= vblnk_i;
            vblnk_prev_q <= vblnk_q;
            tick_q       <= vblnk_q & ~vblnk_prev_q;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/person_motion_ctrl.sv
// person_motion_ctrl: per-frame walk/jump motion for the player sprite, driving its four
// body-part boxes and colours to the drawing stage; boxes change only on the frame tick.
module person_motion_ctrl #(
    parameter int START_X     = 390,
    parameter int GROUND_Y    = 534,
    parameter int X_MIN       = 6,
    parameter int X_MAX       = 774,
    parameter int STEP        = 2,
    parameter int JUMP_V0     = 12,
    parameter int ANIM_FRAMES = 8,
    parameter logic [11:0] RGB_HEAD  = 12'hFC9,
    parameter logic [11:0] RGB_TORSO = 12'h00F,
    parameter logic [11:0] RGB_LEGS  = 12'h333,
    parameter logic [11:0] RGB_ARMS  = 12'hFC9
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [9:0]  VcountMinHead,
    output logic [9:0]  VcountMaxHead,
    output logic [9:0]  HcountMinHead,
    output logic [9:0]  HcountMaxHead,
    output logic [9:0]  VcountMinTorso,
    output logic [9:0]  VcountMaxTorso,
    output logic [9:0]  HcountMinTorso,
    output logic [9:0]  HcountMaxTorso,
    output logic [9:0]  VcountMinLegs,
    output logic [9:0]  VcountMaxLegs,
    output logic [9:0]  HcountMinLegs,
    output logic [9:0]  HcountMaxLegs,
    output logic [9:0]  VcountMinArms,
    output logic [9:0]  VcountMaxArms,
    output logic [9:0]  HcountMinArms,
    output logic [9:0]  HcountMaxArms,
    output logic [11:0] rgb_pixelHead,
    output logic [11:0] rgb_pixelTorso,
    output logic [11:0] rgb_pixelLegs,
    output logic [11:0] rgb_pixelArms,
    output logic        frame_tick
);
    import person_pkg::*;

    localparam int AW = $clog2(ANIM_FRAMES);

    logic [2:0]        sync1_q, sync2_q;
    logic [9:0]        x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic signed [5:0] vy_q, vy_d;
    state_t            st_q, st_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ph_q, ph_d;
    parts_t            parts_q, parts_d;
    logic              lt, rt, jmp_go, air, land, walk, wrap;
    int                xn, yc, v, leg_d, arm_a;

    frame_tick_gen u_tick (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .vblnk_i (vblnk_in),
        .tick_o  (frame_tick)
    );

    always_comb begin
        lt     = sync2_q[0] & ~sync2_q[1];
        rt     = sync2_q[1] & ~sync2_q[0];
        xn     = int'(x_q) + (lt ? -STEP : rt ? STEP : 0);
        xn     = xn < X_MIN ? X_MIN : xn > X_MAX ? X_MAX : xn;
        jmp_go = st_q != JUMP && sync2_q[2];
        air    = jmp_go || st_q == JUMP;
        v      = jmp_go ? JUMP_V0 : air ? int'(vy_q) : 0;
        yc     = int'(y_q) - v;
        yc     = yc < 0 ? 0 : yc;
        land   = air && yc >= GROUND_Y;
        st_d   = land ? STAND : air ? JUMP : (lt | rt) ? WALK : STAND;
        x_d    = 10'(xn);
        y_d    = land ? 11'(GROUND_Y) : 11'(yc);
        vy_d   = (air && !land) ? 6'(v - 1) : 6'sd0;
        // walk animation advances only on frames that end in WALK
        walk   = st_d == WALK;
        wrap   = int'(cnt_q) == ANIM_FRAMES - 1;
        cnt_d  = walk ? (wrap ? '0 : AW'(int'(cnt_q) + 1)) : '0;
        ph_d   = walk & (ph_q ^ wrap);
        leg_d  = walk ? (ph_d ? LEG_SWING : -LEG_SWING) : 0;
        arm_a  = ph_d ? ARM_LIFT : 0;
        parts_d = geom(xn, int'(y_d), leg_d, arm_a);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            x_q     <= 10'(START_X);
            y_q     <= 11'(GROUND_Y);
            vy_q    <= '0;
            st_q    <= STAND;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            parts_q <= geom(START_X, GROUND_Y, 0, 0);
        end else begin
            sync1_q <= {btn_jump, btn_right, btn_left};
            sync2_q <= sync1_q;
            if (frame_tick) begin
                x_q     <= x_d;
                y_q     <= y_d;
                vy_q    <= vy_d;
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                ph_q    <= ph_d;
                parts_q <= parts_d;
            end
        end
    end

    assign HcountMinHead  = parts_q.head.h_min;
    assign HcountMaxHead  = parts_q.head.h_max;
    assign VcountMinHead  = parts_q.head.v_min;
    assign VcountMaxHead  = parts_q.head.v_max;
    assign HcountMinTorso = parts_q.torso.h_min;
    assign HcountMaxTorso = parts_q.torso.h_max;
    assign VcountMinTorso = parts_q.torso.v_min;
    assign VcountMaxTorso = parts_q.torso.v_max;
    assign HcountMinLegs  = parts_q.legs.h_min;
    assign HcountMaxLegs  = parts_q.legs.h_max;
    assign VcountMinLegs  = parts_q.legs.v_min;
    assign VcountMaxLegs  = parts_q.legs.v_max;
    assign HcountMinArms  = parts_q.arms.h_min;
    assign HcountMaxArms  = parts_q.arms.h_max;
    assign VcountMinArms  = parts_q.arms.v_min;
    assign VcountMaxArms  = parts_q.arms.v_max;
    assign rgb_pixelHead  = RGB_HEAD;
    assign rgb_pixelTorso = RGB_TORSO;
    assign rgb_pixelLegs  = RGB_LEGS;
    assign rgb_pixelArms  = RGB_ARMS;
endmodule

// File: tb/tb_person_motion_ctrl.sv
// tb_person_motion_ctrl: scoreboard bench for the player-sprite motion controller.
module tb_person_motion_ctrl;
    logic pclk = 1'b0, rst_n = 1'b0, vblnk_in = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [9:0] VcountMinHead, VcountMaxHead, HcountMinHead, HcountMaxHead;
    logic [9:0] VcountMinTorso, VcountMaxTorso, HcountMinTorso, HcountMaxTorso;
    logic [9:0] VcountMinLegs, VcountMaxLegs, HcountMinLegs, HcountMaxLegs;
    logic [9:0] VcountMinArms, VcountMaxArms, HcountMinArms, HcountMaxArms;
    logic [11:0] rgb_pixelHead, rgb_pixelTorso, rgb_pixelLegs, rgb_pixelArms;
    logic frame_tick;
    logic [159:0] act;
    logic [159:0] exp_q[$];
    int checks = 0, failures = 0;
    int mx, my, mvy, mst, mcnt, mph;

    person_motion_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .VcountMinHead(VcountMinHead), .VcountMaxHead(VcountMaxHead),
        .HcountMinHead(HcountMinHead), .HcountMaxHead(HcountMaxHead),
        .VcountMinTorso(VcountMinTorso), .VcountMaxTorso(VcountMaxTorso),
        .HcountMinTorso(HcountMinTorso), .HcountMaxTorso(HcountMaxTorso),
        .VcountMinLegs(VcountMinLegs), .VcountMaxLegs(VcountMaxLegs),
        .HcountMinLegs(HcountMinLegs), .HcountMaxLegs(HcountMaxLegs),
        .VcountMinArms(VcountMinArms), .VcountMaxArms(VcountMaxArms),
        .HcountMinArms(HcountMinArms), .HcountMaxArms(HcountMaxArms),
        .rgb_pixelHead(rgb_pixelHead), .rgb_pixelTorso(rgb_pixelTorso),
        .rgb_pixelLegs(rgb_pixelLegs), .rgb_pixelArms(rgb_pixelArms),
        .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    assign act = {HcountMinHead, HcountMaxHead, VcountMinHead, VcountMaxHead,
                  HcountMinTorso, HcountMaxTorso, VcountMinTorso, VcountMaxTorso,
                  HcountMinLegs, HcountMaxLegs, VcountMinLegs, VcountMaxLegs,
                  HcountMinArms, HcountMaxArms, VcountMinArms, VcountMaxArms};

    function automatic logic [159:0] exp_vec(input int x, input int y, input int d, input int a);
        return {10'(x + 4), 10'(x + 15), 10'(y), 10'(y + 11),
                10'(x), 10'(x + 19), 10'(y + 12), 10'(y + 41),
                10'(x + 2 + d), 10'(x + 17 + d), 10'(y + 42), 10'(y + 65),
                10'(x - 6), 10'(x + 25), 10'(y + 16 + a), 10'(y + 21 + a)};
    endfunction

    task automatic model_reset();
        mx = 390; my = 534; mvy = 0; mst = 0; mcnt = 0; mph = 0;
    endtask

    // mst: 0 stand, 1 walk, 2 jump
    task automatic model_step(input logic l, input logic r, input logic j);
        if (l && !r) mx = mx - 2;
        if (r && !l) mx = mx + 2;
        if (mx < 6) mx = 6;
        if (mx > 774) mx = 774;
        if (mst != 2 && j) begin
            mst = 2;
            mvy = 12;
        end
        if (mst == 2) begin
            my = my - mvy;
            mvy = mvy - 1;
            if (my >= 534) begin
                my = 534; mvy = 0; mst = 0;
            end
        end else mst = (l != r) ? 1 : 0;
        if (mst == 1) begin
            mcnt = mcnt + 1;
            if (mcnt == 8) begin
                mcnt = 0;
                mph = 1 - mph;
            end
        end else begin
            mcnt = 0; mph = 0;
        end
        exp_q.push_back(exp_vec(mx, my, mst == 1 ? (mph == 1 ? 2 : -2) : 0, mph == 1 ? 2 : 0));
    endtask

    task automatic do_frame(input logic l, input logic r, input logic j);
        logic [159:0] e;
        bit got;
        @(negedge pclk);
        btn_left = l; btn_right = r; btn_jump = j;
        model_step(l, r, j);
        repeat (3) @(negedge pclk);
        vblnk_in = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            if (frame_tick) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL tick_timeout: no frame_tick within 20 cycles");
        end
        @(negedge pclk);
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL boxes: got %h expected %h", act, e);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_width: frame_tick=%b expected 0", frame_tick);
        end
        vblnk_in = 1'b0;
        repeat (4) @(negedge pclk);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL boxes_hold: got %h expected %h", act, e);
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst_n = 1'b0;
        btn_left = 0; btn_right = 0; btn_jump = 0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        checks += 8;
        if (HcountMinHead !== 10'd394 || HcountMaxHead !== 10'd405) begin
            failures++; $display("FAIL reset_head_h: got %0d..%0d expected 394..405", HcountMinHead, HcountMaxHead);
        end
        if (VcountMinHead !== 10'd534 || VcountMaxHead !== 10'd545) begin
            failures++; $display("FAIL reset_head_v: got %0d..%0d expected 534..545", VcountMinHead, VcountMaxHead);
        end
        if (HcountMinLegs !== 10'd392 || HcountMaxLegs !== 10'd407) begin
            failures++; $display("FAIL reset_legs_h: got %0d..%0d expected 392..407", HcountMinLegs, HcountMaxLegs);
        end
        if (act !== exp_vec(390, 534, 0, 0)) begin
            failures++; $display("FAIL reset_boxes: got %h expected %h", act, exp_vec(390, 534, 0, 0));
        end
        if (frame_tick !== 1'b0) begin
            failures++; $display("FAIL reset_tick: got %b expected 0", frame_tick);
        end
        if (rgb_pixelHead !== 12'hFC9 || rgb_pixelArms !== 12'hFC9) begin
            failures++; $display("FAIL rgb_skin: got %h/%h expected fc9", rgb_pixelHead, rgb_pixelArms);
        end
        if (rgb_pixelTorso !== 12'h00F) begin
            failures++; $display("FAIL rgb_torso: got %h expected 00f", rgb_pixelTorso);
        end
        if (rgb_pixelLegs !== 12'h333) begin
            failures++; $display("FAIL rgb_legs: got %h expected 333", rgb_pixelLegs);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_walk();
        do_reset();
        for (int f = 1; f <= 8; f++) begin
            do_frame(0, 1, 0);
            if (f == 3) begin
                checks++;
                if (HcountMinTorso !== 10'd396 || HcountMinLegs !== 10'd396) begin
                    failures++; $display("FAIL walk_x3: torso %0d legs %0d expected 396 396", HcountMinTorso, HcountMinLegs);
                end
            end
        end
        checks++;
        if (HcountMinLegs !== 10'd410 || VcountMinArms !== 10'd552) begin
            failures++; $display("FAIL walk_phase: legs %0d arms_v %0d expected 410 552", HcountMinLegs, VcountMinArms);
        end
        do_frame(0, 0, 0);
        checks++;
        if (HcountMinLegs !== 10'd408) begin
            failures++; $display("FAIL walk_stop: legs %0d expected 408", HcountMinLegs);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int f = 0; f < 191; f++) do_frame(0, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd772) begin
            failures++; $display("FAIL clamp_pre: x %0d expected 772", HcountMinTorso);
        end
        for (int f = 0; f < 3; f++) do_frame(0, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd774) begin
            failures++; $display("FAIL clamp_right: x %0d expected 774", HcountMinTorso);
        end
        do_frame(1, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd774 || HcountMinLegs !== 10'd776) begin
            failures++; $display("FAIL clamp_both: x %0d legs %0d expected 774 776", HcountMinTorso, HcountMinLegs);
        end
        do_frame(1, 0, 0);
        do_frame(1, 0, 0);
        checks++;
        if (HcountMinTorso !== 10'd770) begin
            failures++; $display("FAIL walk_left: x %0d expected 770", HcountMinTorso);
        end
    endtask

    task automatic test_jump();
        int ymin;
        do_reset();
        ymin = 1000;
        do_frame(0, 0, 1);
        checks++;
        if (VcountMinHead !== 10'd522) begin
            failures++; $display("FAIL jump_f1: y %0d expected 522", VcountMinHead);
        end
        do_frame(0, 0, 0);
        checks++;
        if (VcountMinHead !== 10'd511) begin
            failures++; $display("FAIL jump_f2: y %0d expected 511", VcountMinHead);
        end
        do_frame(0, 0, 0);
        checks++;
        if (VcountMinHead !== 10'd501) begin
            failures++; $display("FAIL jump_f3: y %0d expected 501", VcountMinHead);
        end
        do_frame(0, 0, 0);
        do_frame(0, 0, 1);
        checks++;
        if (VcountMinHead !== 10'd484) begin
            failures++; $display("FAIL jump_repress: y %0d expected 484", VcountMinHead);
        end
        for (int f = 6; f <= 24; f++) begin
            do_frame(0, 0, 0);
            if (int'(VcountMinHead) < ymin) ymin = int'(VcountMinHead);
        end
        checks++;
        if (VcountMinHead !== 10'd522) begin
            failures++; $display("FAIL jump_f24: y %0d expected 522", VcountMinHead);
        end
        checks++;
        if (ymin != 456) begin
            failures++; $display("FAIL jump_peak: y %0d expected 456", ymin);
        end
        do_frame(0, 0, 0);
        checks++;
        if (VcountMinHead !== 10'd534 || HcountMinLegs !== 10'd392) begin
            failures++; $display("FAIL jump_land: y %0d legs %0d expected 534 392", VcountMinHead, HcountMinLegs);
        end
        do_frame(0, 0, 0);
    endtask

    task automatic test_jump_walk();
        do_reset();
        do_frame(0, 1, 1);
        for (int f = 2; f <= 25; f++) do_frame(0, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd440 || VcountMinHead !== 10'd534 || HcountMinLegs !== 10'd442) begin
            failures++; $display("FAIL jw_land: x %0d y %0d legs %0d expected 440 534 442", HcountMinTorso, VcountMinHead, HcountMinLegs);
        end
        do_frame(0, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd442 || HcountMinLegs !== 10'd442) begin
            failures++; $display("FAIL jw_walk: x %0d legs %0d expected 442 442", HcountMinTorso, HcountMinLegs);
        end
    endtask

    task automatic test_async_reset();
        int ticks;
        do_reset();
        do_frame(0, 0, 1);
        for (int f = 0; f < 4; f++) do_frame(0, 0, 0);
        checks++;
        if (VcountMinHead !== 10'd484) begin
            failures++; $display("FAIL ar_pre: y %0d expected 484", VcountMinHead);
        end
        @(negedge pclk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (act !== exp_vec(390, 534, 0, 0) || frame_tick !== 1'b0) begin
            failures++; $display("FAIL ar_async: got %h tick %b expected %h 0", act, frame_tick, exp_vec(390, 534, 0, 0));
        end
        vblnk_in = 1'b1;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        model_reset();
        ticks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge pclk);
            if (frame_tick) ticks++;
        end
        checks++;
        if (ticks != 0) begin
            failures++; $display("FAIL vblnk_held: ticks %0d expected 0", ticks);
        end
        vblnk_in = 1'b0;
        repeat (3) @(negedge pclk);
        do_frame(0, 0, 0);
        do_frame(0, 1, 0);
        checks++;
        if (HcountMinTorso !== 10'd392 || VcountMinHead !== 10'd534) begin
            failures++; $display("FAIL ar_after: x %0d y %0d expected 392 534", HcountMinTorso, VcountMinHead);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk();
        test_clamp();
        test_jump();
        test_jump_walk();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
